// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - steps through the internal song ROM, presenting note codes
// with per-entry duration and a trailing articulation gap for the tone generator.
module song_sequencer #(
  parameter int tick_div  = 12,
  parameter int gap_ticks = 1,
  parameter bit loop_en   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] note_code,
  output logic       note_on,
  output logic       note_strobe,
  output logic [4:0] song_idx,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(4 * tick_div);
  localparam logic [4:0] LAST_IDX = 5'd24;

  localparam logic [3:0] NOTES [25] = '{
    4'd1, 4'd1, 4'd2, 4'd1, 4'd4, 4'd3,
    4'd1, 4'd1, 4'd2, 4'd1, 4'd5, 4'd4,
    4'd1, 4'd1, 4'd8, 4'd6, 4'd4, 4'd3, 4'd2,
    4'd7, 4'd7, 4'd6, 4'd4, 4'd5, 4'd4
  };
  localparam logic [2:0] LENS [25] = '{
    3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4,
    3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4,
    3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd4,
    3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4
  };

  typedef enum logic {IDLE, PLAY} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  note_code_q, note_code_d;
  logic        note_on_q, note_on_d;
  logic        note_strobe_q, note_strobe_d;
  logic [4:0]  song_idx_q, song_idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [CW-1:0] last_cnt, on_last;
  logic [4:0]    next_idx;

  // cnt_q is the position inside the current entry; on_last is the final sounding position.
  assign last_cnt = CW'(int'(LENS[song_idx_q]) * tick_div - 1);
  assign on_last  = CW'(int'(LENS[song_idx_q]) * tick_div - gap_ticks - 1);
  assign next_idx = song_idx_q + 5'd1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    note_code_d   = note_code_q;
    note_on_d     = note_on_q;
    note_strobe_d = 1'b0;
    song_idx_d    = song_idx_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d       = PLAY;
          cnt_d         = '0;
          song_idx_d    = 5'd0;
          note_code_d   = NOTES[0];
          note_on_d     = 1'b1;
          note_strobe_d = 1'b1;
          busy_d        = 1'b1;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d     = IDLE;
          cnt_d       = '0;
          note_code_d = 4'd0;
          note_on_d   = 1'b0;
          song_idx_d  = 5'd0;
          busy_d      = 1'b0;
        end else if (cnt_q == last_cnt) begin
          cnt_d = '0;
          if (song_idx_q == LAST_IDX) begin
            done_d     = 1'b1;
            song_idx_d = 5'd0;
            if (loop_en) begin
              note_code_d   = NOTES[0];
              note_on_d     = 1'b1;
              note_strobe_d = 1'b1;
            end else begin
              state_d     = IDLE;
              note_code_d = 4'd0;
              note_on_d   = 1'b0;
              busy_d      = 1'b0;
            end
          end else begin
            song_idx_d    = next_idx;
            note_code_d   = NOTES[next_idx];
            note_on_d     = 1'b1;
            note_strobe_d = 1'b1;
          end
        end else begin
          cnt_d     = cnt_q + 1'b1;
          note_on_d = (cnt_q < on_last);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      note_code_q   <= 4'd0;
      note_on_q     <= 1'b0;
      note_strobe_q <= 1'b0;
      song_idx_q    <= 5'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      note_code_q   <= note_code_d;
      note_on_q     <= note_on_d;
      note_strobe_q <= note_strobe_d;
      song_idx_q    <= song_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign note_code   = note_code_q;
  assign note_on     = note_on_q;
  assign note_strobe = note_strobe_q;
  assign song_idx    = song_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - bench for song_sequencer: three configurations (defaults,
// looping, small tick values) checked with directed scenarios and a randomized model run.
module tb_song_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [2:0]      start = '0;
  logic [2:0]      stop = '0;
  logic [2:0][3:0] code;
  logic [2:0][4:0] idx;
  logic [2:0]      on, strb, busy, done;

  int vectors = 0;
  int errors  = 0;

  int notes [25] = '{1,1,2,1,4,3, 1,1,2,1,5,4, 1,1,8,6,4,3,2, 7,7,6,4,5,4};
  int lens  [25] = '{1,1,2,2,2,4, 1,1,2,2,2,4, 1,1,2,2,2,2,4, 1,1,2,2,2,4};
  int td [3] = '{12, 12, 2};
  int gp [3] = '{1, 1, 1};
  int lp [3] = '{0, 1, 0};

  bit m_play [3];
  int m_t    [3];
  bit m_done [3];

  song_sequencer #(.tick_div(12), .gap_ticks(1), .loop_en(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .stop(stop[0]), .note_code(code[0]),
    .note_on(on[0]), .note_strobe(strb[0]), .song_idx(idx[0]), .busy(busy[0]), .done(done[0]));
  song_sequencer #(.tick_div(12), .gap_ticks(1), .loop_en(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .stop(stop[1]), .note_code(code[1]),
    .note_on(on[1]), .note_strobe(strb[1]), .song_idx(idx[1]), .busy(busy[1]), .done(done[1]));
  song_sequencer #(.tick_div(2), .gap_ticks(1), .loop_en(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .stop(stop[2]), .note_code(code[2]),
    .note_on(on[2]), .note_strobe(strb[2]), .song_idx(idx[2]), .busy(busy[2]), .done(done[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] dut_out(int d);
    return {code[d], on[d], strb[d], idx[d], busy[d], done[d]};
  endfunction

  // Song position is a plain elapsed-cycle count; the entry is found from running sums of lengths.
  function automatic logic [12:0] model_out(int d);
    int acc, i, off;
    if (!m_play[d]) return {12'd0, m_done[d]};
    acc = 0;
    i = 0;
    while (m_t[d] >= acc + lens[i] * td[d]) begin
      acc += lens[i] * td[d];
      i++;
    end
    off = m_t[d] - acc;
    return {4'(notes[i]), (off < lens[i] * td[d] - gp[d]), (off == 0), 5'(i), 1'b1, m_done[d]};
  endfunction

  function automatic void model_step(int d, bit r, bit s, bit p);
    if (r) begin
      m_play[d] = 1'b0;
      m_done[d] = 1'b0;
    end else if (m_play[d]) begin
      m_done[d] = 1'b0;
      if (p) m_play[d] = 1'b0;
      else begin
        m_t[d]++;
        if (m_t[d] == 50 * td[d]) begin
          m_done[d] = 1'b1;
          m_t[d] = 0;
          if (lp[d] == 0) m_play[d] = 1'b0;
        end
      end
    end else begin
      m_done[d] = 1'b0;
      if (s && !p) begin
        m_play[d] = 1'b1;
        m_t[d] = 0;
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (dut_out(d) !== 13'd0) begin
        errors++;
        $display("FAIL reset dut%0d: got %h expected 0000", d, dut_out(d));
      end
    end
  endtask

  task automatic test_first_entries();
    logic [4:0] eidx;
    logic [3:0] ecode;
    repeat (9) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    vectors++;
    if (dut_out(0) !== {4'd1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL first_entry: got %h expected %h", dut_out(0), {4'd1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0});
    end
    for (int rel = 1; rel <= 48; rel++) begin
      if (rel == 30) start[0] = 1'b1;
      if (rel == 32) start[0] = 1'b0;
      tick();
      if (rel == 10 || rel == 11) begin
        vectors++;
        if (on[0] !== (rel == 10)) begin
          errors++;
          $display("FAIL gap rel%0d: note_on got %b expected %b", rel, on[0], (rel == 10));
        end
      end
      if (rel == 12 || rel == 24 || rel == 48) begin
        eidx  = (rel == 48) ? 5'd3 : 5'(rel / 12);
        ecode = (rel == 24) ? 4'd2 : 4'd1;
        vectors++;
        if ({strb[0], idx[0], code[0]} !== {1'b1, eidx, ecode}) begin
          errors++;
          $display("FAIL entry_strobe rel%0d: got strb=%b idx=%0d code=%0d expected 1/%0d/%0d",
                   rel, strb[0], idx[0], code[0], eidx, ecode);
        end
      end
    end
  endtask

  task automatic test_stop();
    logic seen;
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;
    vectors++;
    if (dut_out(0) !== 13'd0) begin
      errors++;
      $display("FAIL stop_idle: got %h expected 0000", dut_out(0));
    end
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= done[0] | busy[0];
    end
    vectors++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL stop_no_done: got %b expected 0", seen);
    end
    start[0] = 1'b1;
    stop[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    stop[0] = 1'b0;
    vectors++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_idle: busy got %b expected 0", busy[0]);
    end
  endtask

  task automatic test_full_song();
    int ons, dones;
    logic [3:0] seq[$];
    ons = 0;
    dones = 0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int rel = 0; rel <= 601; rel++) begin
      if (rel > 0) tick();
      ons += int'(on[0]);
      dones += int'(done[0]);
      if (strb[0]) seq.push_back(code[0]);
      if (rel == 600) begin
        vectors++;
        if ({done[0], busy[0]} !== 2'b10) begin
          errors++;
          $display("FAIL song_done: done=%b busy=%b expected 1/0", done[0], busy[0]);
        end
      end
    end
    vectors++;
    if (seq.size() != 25) begin
      errors++;
      $display("FAIL strobe_count: got %0d expected 25", seq.size());
    end
    for (int i = 0; i < 25 && i < seq.size(); i++) begin
      vectors++;
      if (seq[i] !== 4'(notes[i])) begin
        errors++;
        $display("FAIL note_seq[%0d]: got %0d expected %0d", i, seq[i], notes[i]);
      end
    end
    vectors++;
    if (ons != 575) begin
      errors++;
      $display("FAIL on_cycles: got %0d expected 575", ons);
    end
    vectors++;
    if (dones != 1) begin
      errors++;
      $display("FAIL done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_reset_mid();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (188) tick();
    rst = 1'b1;
    start[0] = 1'b1;
    tick();
    rst = 1'b0;
    start[0] = 1'b0;
    vectors++;
    if (dut_out(0) !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 0000", dut_out(0));
    end
    tick();
    vectors++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_with_rst: busy got %b expected 0", busy[0]);
    end
  endtask

  task automatic test_loop();
    int st[$];
    int busy_low, acc;
    busy_low = 0;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int rel = 0; rel <= 1200; rel++) begin
      if (rel > 0) tick();
      if (strb[1]) st.push_back(rel);
      if (!busy[1]) busy_low++;
      if (rel == 600 || rel == 1200) begin
        vectors++;
        if ({done[1], strb[1], idx[1], busy[1]} !== {1'b1, 1'b1, 5'd0, 1'b1}) begin
          errors++;
          $display("FAIL loop_wrap rel%0d: done=%b strb=%b idx=%0d busy=%b expected 1/1/0/1",
                   rel, done[1], strb[1], idx[1], busy[1]);
        end
      end
    end
    vectors++;
    if (busy_low != 0 || st.size() != 51) begin
      errors++;
      $display("FAIL loop_counts: busy_low=%0d strobes=%0d expected 0/51", busy_low, st.size());
    end
    acc = 0;
    for (int i = 0; i < 25 && i + 25 < st.size(); i++) begin
      vectors++;
      if (st[i] != acc || st[i + 25] != acc + 600) begin
        errors++;
        $display("FAIL loop_timing[%0d]: got %0d/%0d expected %0d/%0d", i, st[i], st[i + 25], acc, acc + 600);
      end
      acc += lens[i] * 12;
    end
    stop[1] = 1'b1;
    tick();
    stop[1] = 1'b0;
    vectors++;
    if (dut_out(1) !== 13'd0) begin
      errors++;
      $display("FAIL loop_stop: got %h expected 0000", dut_out(1));
    end
  endtask

  task automatic test_small();
    int ons;
    ons = 0;
    start[2] = 1'b1;
    tick();
    for (int rel = 0; rel <= 101; rel++) begin
      if (rel > 0) tick();
      if (rel < 100) ons += int'(on[2]);
      if (rel <= 1) begin
        vectors++;
        if (on[2] !== (rel == 0)) begin
          errors++;
          $display("FAIL small_gap rel%0d: note_on got %b expected %b", rel, on[2], (rel == 0));
        end
      end
      if (rel == 2) begin
        vectors++;
        if ({strb[2], idx[2]} !== {1'b1, 5'd1}) begin
          errors++;
          $display("FAIL small_entry1: strb=%b idx=%0d expected 1/1", strb[2], idx[2]);
        end
      end
      if (rel == 100) begin
        vectors++;
        if ({done[2], busy[2]} !== 2'b10) begin
          errors++;
          $display("FAIL small_done: done=%b busy=%b expected 1/0", done[2], busy[2]);
        end
      end
      if (rel == 101) begin
        vectors++;
        if ({strb[2], idx[2], busy[2], done[2]} !== {1'b1, 5'd0, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL small_restart: strb=%b idx=%0d busy=%b done=%b expected 1/0/1/0",
                   strb[2], idx[2], busy[2], done[2]);
        end
      end
    end
    start[2] = 1'b0;
    vectors++;
    if (ons != 75) begin
      errors++;
      $display("FAIL small_on_cycles: got %0d expected 75", ons);
    end
    stop[2] = 1'b1;
    tick();
    stop[2] = 1'b0;
  endtask

  task automatic test_random_traffic();
    bit r;
    bit [2:0] s, p;
    int shown;
    shown = 0;
    rst = 1'b1;
    start = '0;
    stop = '0;
    tick();
    for (int d = 0; d < 3; d++) model_step(d, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 5000; c++) begin
      r = ($urandom_range(0, 1499) == 0);
      for (int d = 0; d < 3; d++) begin
        s[d] = ($urandom_range(0, 5) == 0);
        p[d] = ($urandom_range(0, 1499) == 0);
      end
      rst = r;
      start = s;
      stop = p;
      tick();
      for (int d = 0; d < 3; d++) begin
        model_step(d, r, s[d], p[d]);
        vectors++;
        if (dut_out(d) !== model_out(d)) begin
          errors++;
          if (shown < 20) $display("FAIL random dut%0d cycle %0d: got %h expected %h", d, c, dut_out(d), model_out(d));
          shown++;
        end
      end
    end
    rst = 1'b0;
    start = '0;
    stop = '0;
  endtask

  initial begin
    test_reset();
    test_first_entries();
    test_stop();
    test_full_song();
    test_reset_mid();
    test_loop();
    test_small();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Upstream sequencing stage for the tone generator.
- Steps through a fixed internal song ROM (Happy Birthday in F, 25 entries) and presents one note code at a time, with per-note duration and an articulation gap.
- Tone generator consumes note_code/note_on and produces the square wave on the speaker.
- Durations are counted in clock ticks so benches can use small test values.

Parameters:
- tick_div, 12: clocks per duration unit (one eighth note); must be ≥ 2.
- gap_ticks, 1: clocks of silence (note_on=0) at the end of every entry; must satisfy 1 ≤ gap_ticks < tick_div.
- loop_en, 0: 1 restarts at entry 0 after the last entry; 0 returns to idle.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  level-sampled; begins playback when idle
- stop  input  1  level-sampled; aborts playback
- note_code  output  4  0=rest, 1=C, 2=D, 3=E, 4=F, 5=G, 6=A, 7=A#, 8=C'(octave up); 9–15 unused
- note_on  output  1  1 while the tone generator is to sound note_code
- note_strobe  output  1  one-cycle pulse on the first cycle of each entry
- song_idx  output  5  current ROM entry index, 0..24
- busy  output  1  1 while playing
- done  output  1  one-cycle pulse at song end

Behaviour:
- ROM entries are {note[3:0], len[2:0]}, with len in units of tick_div. Contents in order:
  - C1 C1 D2 C2 F2 E4
  - C1 C1 D2 C2 G2 F4
  - C1 C1 C'2 A2 F2 E2 D4
  - A#1 A#1 A2 F2 G2 F4
- Sum of len = 50 units, so one pass takes 50·tick_div clocks (600 with defaults).
- States: IDLE, PLAY.
- Reset (rst=1 at an edge): state=IDLE, note_code=0, note_on=0, note_strobe=0, song_idx=0, busy=0, done=0, tick counter=0. Reset mid-song aborts immediately; no done pulse.
- IDLE → PLAY:
  - Condition: start=1 and stop=0 sampled at edge k.
  - From edge k+1: busy=1, song_idx=0, note_code=4'd1, note_on=1, note_strobe=1.
  - Latency: 1 cycle.
- PLAY, per entry of length L:
  - The entry occupies exactly L·tick_div cycles.
  - note_on=1 for the first L·tick_div − gap_ticks cycles, then 0 for gap_ticks cycles.
  - note_code holds the entry's value for the whole entry, including the gap.
  - note_strobe=1 only on the entry's first cycle.
- Entry advance: on the cycle after an entry's last cycle, song_idx increments and the next entry begins with note_strobe=1 and note_on=1. There are no idle cycles between entries.
- After entry 24 ends, with loop_en=0:
  - Next cycle: state=IDLE, busy=0, done=1 for exactly one cycle.
  - note_on=0, note_code=0, song_idx=0.
- After entry 24 ends, with loop_en=1:
  - Next cycle: song_idx=0, entry 0 starts with note_strobe=1, done=1 for one cycle, busy stays 1.
- start while in PLAY is ignored.
- stop=1 sampled at any edge in PLAY:
  - Next cycle: IDLE with all outputs at reset values; no done pulse.
  - stop in IDLE has no effect.
  - start and stop both high in IDLE: stop wins, stays IDLE.
- Tick counter width: enough for 4·tick_div−1 (longest entry). It reloads on each entry and never wraps mid-entry.
- Outputs are registered; there are no combinational paths from start/stop to outputs.

Test Plan:
1. Defaults (tick_div=12, gap_ticks=1, loop_en=0): rst, then start pulse at cycle 10.
   - Cycle 11: note_strobe=1, note_code=1, song_idx=0.
   - note_on falls at cycle 22, entry 1 strobes at cycle 23.
   - Entry 2 (D, len 2) strobes at cycle 35; entry 3 strobes at cycle 59.
2. Full song, defaults:
   - Exactly 25 note_strobe pulses, with note_code sequence 1,1,2,1,4,3,1,1,2,1,5,4,1,1,8,6,4,3,2,7,7,6,4,5,4.
   - done pulses at cycle 11+600 with busy=0.
   - Sum of note_on-high cycles = 600−25 = 575.
3. Mid-song stop:
   - stop=1 at cycle 100 → at cycle 101 busy=0, note_on=0, song_idx=0, done never asserted.
   - A subsequent start replays from entry 0.
4. Reset mid-song (rst=1 at cycle 200 for one cycle):
   - All outputs 0 the next cycle.
   - start asserted together with rst is ignored.
5. loop_en=1:
   - At the end of pass 1: done=1 and note_strobe=1 with song_idx=0 in the same cycle, busy stays 1.
   - Second pass is identical in timing.
6. Small values (tick_div=2, gap_ticks=1):
   - Each len-1 entry gives note_on high 1 cycle and low 1 cycle.
   - Full song takes 100 cycles.
   - start held high continuously after done restarts the song one cycle after the done pulse.
